// File: rtl/session_pkg.sv
// Shared types and constants for the session controller and its inactivity timer.
// The optional inactivity timeout is enabled by defining SESSION_TIMEOUT_EN.
package session_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_LOGOUT   = 2'd2,
    ST_WAIT_CLR = 2'd3
  } session_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_USER    = 2'd1,
    CAUSE_GUEST   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } logout_cause_t;

  localparam int TIMER_W = 20;

  // Round counter increment that sticks at 15 instead of wrapping.
  function automatic logic [3:0] satIncRounds(input logic [3:0] rounds, input logic inc);
    logic [4:0] sum;
    sum = {1'b0, rounds} + {4'b0000, inc};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Down-counting inactivity timer. Only instantiated when SESSION_TIMEOUT_EN is defined.
// 'reload' loads TIMEOUT_CYCLES, 'enable' lets it count down, and 'expired' flags the
// cycle in which the counter sits at 1 without being reloaded.
module inactivity_timer
  import session_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LoadValue = TIMER_W'(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] r_count;

  // Reload on activity, otherwise count down while enabled, never below zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (reload) begin
      r_count <= LoadValue;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = enable && !reload && (r_count == TIMER_W'(1));

endmodule

// File: rtl/session_controller.sv
// Game session controller: tracks one logged-in player session, counts rounds and
// issues a one-cycle logout pulse on user request, guest round limit or inactivity.
// Define SESSION_TIMEOUT_EN to build in the inactivity timeout (cause 3).
module session_controller
  import session_pkg::*;
#(
  parameter int TIMEOUT_CYCLES   = 1000,
  parameter int GUEST_MAX_ROUNDS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LoggedIn,
  input  logic [2:0] PlayerID_from_pswd,
  input  logic       isGuest_from_PSWD,
  input  logic       UserLoad,
  input  logic       RoundDone,
  input  logic       LogoutReq,
  output logic       logout_from_gamectrl,
  output logic       SessionActive,
  output logic [2:0] ActivePlayerID,
  output logic [3:0] RoundsPlayed,
  output logic [1:0] LogoutCause
);

  session_state_t r_state;
  logout_cause_t  r_cause;
  logout_cause_t  w_exitCause;
  logic           r_logout;
  logic           r_sessionActive;
  logic           r_isGuest;
  logic [2:0]     r_playerId;
  logic [3:0]     r_rounds;
  logic [4:0]     w_roundSum;
  logic           w_guestLimit;
  logic           w_timerExpired;

`ifdef SESSION_TIMEOUT_EN
  logic w_timerReload;
  logic w_timerEnable;

  assign w_timerEnable = (r_state == ST_ACTIVE);
  assign w_timerReload = ((r_state == ST_IDLE) && LoggedIn) ||
                         (w_timerEnable && (UserLoad || RoundDone));

  inactivity_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .reload (w_timerReload),
    .enable (w_timerEnable),
    .expired(w_timerExpired)
  );
`else
  assign w_timerExpired = 1'b0;
`endif

  // The guest limit looks at the count including a round finishing this cycle.
  assign w_roundSum   = {1'b0, r_rounds} + {4'b0000, RoundDone};
  assign w_guestLimit = r_isGuest && (w_roundSum >= 5'(GUEST_MAX_ROUNDS));

  // Pick the highest-priority reason to end the session this cycle, if any.
  always_comb begin
    w_exitCause = CAUSE_NONE;
    if (LogoutReq) begin
      w_exitCause = CAUSE_USER;
    end else if (w_guestLimit) begin
      w_exitCause = CAUSE_GUEST;
    end else if (w_timerExpired) begin
      w_exitCause = CAUSE_TIMEOUT;
    end
  end

  // Session FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_cause         <= CAUSE_NONE;
      r_logout        <= 1'b0;
      r_sessionActive <= 1'b0;
      r_isGuest       <= 1'b0;
      r_playerId      <= '0;
      r_rounds        <= '0;
    end else begin
      r_logout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (LoggedIn) begin
            r_state         <= ST_ACTIVE;
            r_sessionActive <= 1'b1;
            r_playerId      <= PlayerID_from_pswd;
            r_isGuest       <= isGuest_from_PSWD;
            r_rounds        <= '0;
            r_cause         <= CAUSE_NONE;
          end
        end
        ST_ACTIVE: begin
          r_rounds <= satIncRounds(r_rounds, RoundDone);
          if (w_exitCause != CAUSE_NONE) begin
            r_state         <= ST_LOGOUT;
            r_cause         <= w_exitCause;
            r_logout        <= 1'b1;
            r_sessionActive <= 1'b0;
          end else if (!LoggedIn) begin
            r_state         <= ST_IDLE;
            r_sessionActive <= 1'b0;
          end
        end
        ST_LOGOUT: begin
          r_state <= ST_WAIT_CLR;
        end
        ST_WAIT_CLR: begin
          if (!LoggedIn) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign logout_from_gamectrl = r_logout;
  assign SessionActive        = r_sessionActive;
  assign ActivePlayerID       = r_playerId;
  assign RoundsPlayed         = r_rounds;
  assign LogoutCause          = r_cause;

endmodule
